if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage ARM pipeline; sits directly upstream of the ID stage.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Contains the IF/ID pipeline register that feeds the decode stage its instruction and PC+4.
- Honours hazard freeze from hazard detection and branch redirect/flush from EXE; inserts bubbles while memory is slow.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  hazard stall; IF/ID holds, PC does not advance.
- branch_taken  in  1  EXE redirect; flushes IF/ID and loads branch_addr.
- branch_addr  in  32  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  response valid this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  IF/ID entry holds a real instruction.
- if_instruction  out  32  IF/ID instruction; 0 when not valid.
- if_pc  out  32  IF/ID PC+PC_STEP of the held instruction; 0 when not valid.

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, if_valid=0, if_instruction=0, if_pc=0, redirect_pending=0, hold buffer empty. imem_req=0 during the reset cycle. Memory abandons any in-flight access on rst; responses are never consumed during rst.
- States: FETCH, DISCARD, HOLD.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & !branch_taken & !freeze: IF/ID <= {1, rdata, pc+PC_STEP}; pc += PC_STEP.
  - ready & !branch_taken & freeze: rdata and pc+PC_STEP go to the hold buffer; -> HOLD; pc += PC_STEP.
  - ready & branch_taken: response dropped; pc <= branch_addr; stay FETCH.
  - !ready & branch_taken: target latched in redirect register; -> DISCARD (address must stay stable).
  - !ready & !branch_taken: stay FETCH.
- DISCARD: imem_req=1, imem_addr unchanged. On ready, data dropped and pc <= latched target; -> FETCH. A new branch_taken here overwrites the latched target (youngest wins).
- HOLD: imem_req=0.
  - freeze=0: IF/ID <= buffer; -> FETCH.
  - branch_taken: buffer discarded; pc <= branch_addr; -> FETCH.
- IF/ID register priority: rst > branch_taken (clear to bubble) > freeze (hold) > new instruction > bubble (valid=0, instr=0, pc=0).
- Latency: imem_ready in cycle N -> if_valid/if_instruction visible in N+1. Zero-wait memory gives one instruction per cycle.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- branch_taken and freeze together: the branch wins; the freeze is ignored for IF that cycle.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined:
  - Adds 32-bit outputs perf_fetch_cnt (accepted instructions loaded into IF/ID with valid=1) and perf_bubble_cnt (cycles IF/ID loaded a bubble because of memory wait or DISCARD).
  - Both clear on rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package arm_pipe_pkg:
  - state enum if_state_t {FETCH, DISCARD, HOLD}.
  - NOP_INSTR=32'h0.
  - PC_W=32.
- Natural sub-module: if_id_reg, the IF/ID register with flush/freeze/load priority.
- The FSM and PC stay in the top module.

Test Plan:
- Zero-wait memory, rst released at RESET_PC=0: if_pc sequence 4,8,12 on consecutive cycles with if_valid=1 and instructions matching the memory image.
- imem_ready low 2 cycles on address 8: two bubble cycles (if_valid=0, instr=0), then instr@8 with if_pc=12; imem_addr held at 8 throughout.
- freeze=1 for 3 cycles while ready: IF/ID holds the prior instruction, the new response sits in the buffer with imem_req=0; on release the buffered instr appears with its if_pc and no instruction is lost or duplicated.
- branch_taken with branch_addr=0x100 while the request to 0x10 is pending, then ready two cycles later: 0x10 data dropped, next request issued at 0x100, IF/ID shows bubble until instr@0x100 (if_pc=0x104).
- branch_taken and freeze asserted in the same cycle: IF/ID cleared, pc=branch_addr next cycle.
- rst pulsed mid-wait at pc=0x40: outputs zero, next fetch at RESET_PC; under IF_FETCH_PERF_EN both counters read 0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline front end.
// Contents: if_state_t (fetch FSM states), NOP_INSTR, PC_W,
//           ifid_entry_t (IF/ID payload) and pc_add (modulo PC increment).
package arm_pipe_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } if_state_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } ifid_entry_t;

  // 32-bit modulo PC increment; wrap past 32'hFFFF_FFFC is silent.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                             input int unsigned     step);
    return pc + PC_W'(step);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// Signals: imem_req/imem_addr (fetch side -> memory),
//          imem_ready/imem_rdata (memory -> fetch side).
// Modports: master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  import arm_pipe_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [PC_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Priority: rst > flush (bubble) > freeze (hold) > load (new entry) > bubble.
// Ports: clk, rst, flush, freeze, load, load_instr, load_pc in;
//        entry out (valid/instr/pc, all zero when a bubble).
module if_id_reg
  import arm_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            freeze,
  input  logic            load,
  input  logic [PC_W-1:0] load_instr,
  input  logic [PC_W-1:0] load_pc,
  output ifid_entry_t     entry
);

  localparam ifid_entry_t BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= BUBBLE;
    end else if (flush) begin
      entry <= BUBBLE;
    end else if (freeze) begin
      entry <= entry;
    end else if (load) begin
      entry <= '{valid: 1'b1, instr: load_instr, pc: load_pc};
    end else begin
      entry <= BUBBLE;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM (FETCH/DISCARD/HOLD),
// redirect latch, one-entry hold buffer and the IF/ID register.
// Ports: clk, rst (sync, active high), freeze, branch_taken, branch_addr in;
//        imem (if_fetch_unit_if.master) request/response bus;
//        if_valid, if_instruction, if_pc out (IF/ID contents).
// Optional: define IF_FETCH_PERF_EN to add perf_fetch_cnt / perf_bubble_cnt.
module if_fetch_unit
  import arm_pipe_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_addr,
  if_fetch_unit_if.master imem,
  output logic            if_valid,
  output logic [PC_W-1:0] if_instruction,
  output logic [PC_W-1:0] if_pc
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  if_state_t       state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] hold_instr;
  logic [PC_W-1:0] hold_pc;
  logic            ready;

  logic            ifid_load;
  logic [PC_W-1:0] ifid_load_instr;
  logic [PC_W-1:0] ifid_load_pc;
  ifid_entry_t     ifid;

  assign pc_inc = pc_add(pc, PC_STEP);
  assign ready  = imem.imem_ready;

  // Request is a decode of the state register; forced low while rst is held
  // so no response is ever consumed during reset.
  assign imem.imem_req  = (state != HOLD) && !rst;
  // pc is not touched while waiting in FETCH/DISCARD, so the address stays stable.
  assign imem.imem_addr = pc;

  // Fetch FSM, PC, redirect latch and hold buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      redirect_target <= '0;
      hold_instr      <= NOP_INSTR;
      hold_pc         <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (ready) begin
            if (branch_taken) begin
              pc <= branch_addr;
            end else begin
              pc <= pc_inc;
              if (freeze) begin
                hold_instr <= imem.imem_rdata;
                hold_pc    <= pc_inc;
                state      <= HOLD;
              end
            end
          end else if (branch_taken) begin
            // Access in flight: keep address, drop its data when it returns.
            redirect_target <= branch_addr;
            state           <= DISCARD;
          end
        end
        DISCARD: begin
          if (ready) begin
            pc    <= branch_taken ? branch_addr : redirect_target;
            state <= FETCH;
          end else if (branch_taken) begin
            redirect_target <= branch_addr;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc         <= branch_addr;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
            state      <= FETCH;
          end else if (!freeze) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID load request; flush and freeze priority is resolved in if_id_reg.
  always_comb begin
    ifid_load       = 1'b0;
    ifid_load_instr = imem.imem_rdata;
    ifid_load_pc    = pc_inc;
    case (state)
      FETCH: ifid_load = ready;
      HOLD: begin
        ifid_load       = 1'b1;
        ifid_load_instr = hold_instr;
        ifid_load_pc    = hold_pc;
      end
      default: ifid_load = 1'b0;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_taken),
    .freeze     (freeze),
    .load       (ifid_load),
    .load_instr (ifid_load_instr),
    .load_pc    (ifid_load_pc),
    .entry      (ifid)
  );

  assign if_valid       = ifid.valid;
  assign if_instruction = ifid.instr;
  assign if_pc          = ifid.pc;

`ifdef IF_FETCH_PERF_EN
  // Fetches count real loads; bubbles count memory-wait / DISCARD cycles only.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (!branch_taken && !freeze) begin
      if (ifid_load) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end else begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
